// File: rtl/sram_request_arbiter_pkg.sv
// Shared types for the two-port SRAM request arbiter: FSM states,
// requester port ids and the operation encoding.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic P0 = 1'b0;  // MEM-stage data access
  localparam logic P1 = 1'b1;  // instruction-fetch refill

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // A requester raising rd and wr together is serviced as a write.
  function automatic op_t op_of(input logic wr);
    return wr ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/sram_request_arbiter_if.sv
// Bundle of the requester-side and controller-side signals of the arbiter.
// slave = arbiter view, master = view of whoever drives requests and the
// controller responses.
interface sram_request_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              r0_rd;
  logic              r0_wr;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_done;

  logic              r1_rd;
  logic              r1_wr;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_done;

  logic [DATA_W-1:0] rd_data;

  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              err_timeout;

  modport slave (
    input  r0_rd, r0_wr, r0_addr, r0_wdata,
    input  r1_rd, r1_wr, r1_addr, r1_wdata,
    input  mem_rdata, mem_ready,
    output r0_done, r1_done, rd_data,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    output err_timeout
  );

  modport master (
    output r0_rd, r0_wr, r0_addr, r0_wdata,
    output r1_rd, r1_wr, r1_addr, r1_wdata,
    output mem_rdata, mem_ready,
    input  r0_done, r1_done, rd_data,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    input  err_timeout
  );
endinterface

// File: rtl/sram_request_arbiter_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester wins,
// a tie goes to the port that did not win last time.
module sram_rr_pick
  import sram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  // Pick the winner from the current requests and the previous winner.
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_id_o    = P0;
    if (req_i == 2'b11) begin
      gnt_id_o = ~last_i;
    end else if (req_i[1]) begin
      gnt_id_o = P1;
    end
  end

endmodule

// File: rtl/sram_request_arbiter.sv
// Shares one SRAM controller port between the MEM-stage requester (port 0)
// and the fetch-refill requester (port 1). One transaction in flight at a
// time; a watchdog ends a transaction whose ready never arrives.
module sram_request_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   rst,
  sram_request_arbiter_if.slave bus
);

  localparam int              WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  state_t            state_q,   state_d;
  logic              last_q,    last_d;
  logic              gnt_q,     gnt_d;
  op_t               op_q,      op_d;
  logic              rd_en_q,   rd_en_d;
  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              done0_q,   done0_d;
  logic              done1_q,   done1_d;
  logic [WD_W-1:0]   wd_q,      wd_d;
  logic              err_q,     err_d;

  logic [1:0]        req;
  logic              gnt_valid;
  logic              gnt_id;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign req = {bus.r1_rd | bus.r1_wr, bus.r0_rd | bus.r0_wr};

  sram_rr_pick u_pick (
    .req_i       (req),
    .last_i      (last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  assign win_wr    = (gnt_id == P1) ? bus.r1_wr    : bus.r0_wr;
  assign win_addr  = (gnt_id == P1) ? bus.r1_addr  : bus.r0_addr;
  assign win_wdata = (gnt_id == P1) ? bus.r1_wdata : bus.r0_wdata;

  // Next-state and datapath capture; done pulses default low so they last
  // exactly the DONE cycle.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    op_d      = op_q;
    rd_en_d   = rd_en_q;
    wr_en_d   = wr_en_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    wd_d      = wd_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          gnt_d   = gnt_id;
          op_d    = op_of(win_wr);
          rd_en_d = (op_of(win_wr) == OP_RD);
          wr_en_d = (op_of(win_wr) == OP_WR);
          addr_d  = win_addr;
          wdata_d = win_wdata;
          wd_d    = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ready || (wd_q == WD_LIMIT)) begin
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          if (bus.mem_ready) begin
            if (op_q == OP_RD) rd_data_d = bus.mem_rdata;
          end else begin
            err_d = 1'b1;  // watchdog expiry; rd_data left untouched
          end
          done0_d = (gnt_q == P0);
          done1_d = (gnt_q == P1);
          last_d  = gnt_q;
          state_d = DONE;
        end else begin
          // Reaching WD_LIMIT always leaves BUSY, so the count stops there
          // and never wraps.
          wd_d = wd_q + 1'b1;
        end
      end
      DONE: begin
        // Enables stay low for this cycle so the controller re-arms.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset also drops the enables, aborting the
  // controller mid-transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= P1;
      gnt_q     <= P0;
      op_q      <= OP_RD;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      wd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      op_q      <= op_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
    end
  end

  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.r0_done     = done0_q;
  assign bus.r1_done     = done1_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_sram_request_arbiter.sv
// Testbench for sram_request_arbiter: directed scenarios plus a randomized
// two-requester run checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_sram_request_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_request_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_request_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Controller model: ready after ctl_lat enable cycles (never when stalled).
  logic [31:0] sram [64];
  int          ctl_lat   = 6;
  bit          ctl_stall = 1'b0;
  int          en_cnt    = 0;

  function automatic int idx(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !(bus.mem_rd_en || bus.mem_wr_en)) begin
        en_cnt        = 0;
        bus.mem_ready = 1'b0;
      end else begin
        en_cnt++;
        bus.mem_ready = !ctl_stall && (en_cnt >= ctl_lat);
        if (bus.mem_ready && bus.mem_wr_en) sram[idx(bus.mem_addr)] = bus.mem_wdata;
      end
      bus.mem_rdata = (bus.mem_ready && bus.mem_rd_en) ? sram[idx(bus.mem_addr)] : $urandom;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang want finish");
    $fatal(1, "bench hung");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_reqs();
    bus.r0_rd = 1'b0; bus.r0_wr = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_rd = 1'b0; bus.r1_wr = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
  endtask

  // Observe until the given port's done pulse; returns cycle indices (-1 if absent).
  task automatic wait_done(input int port, input int limit,
                           output int ready_at, output int done_at);
    ready_at = -1;
    done_at  = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if ((port == 0) ? bus.r0_done : bus.r1_done) begin
        done_at = i;
        return;
      end
      if (bus.mem_ready && (bus.mem_rd_en || bus.mem_wr_en)) ready_at = i;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({bus.mem_rd_en, bus.mem_wr_en, bus.r0_done, bus.r1_done, bus.err_timeout} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.mem_rd_en, bus.mem_wr_en, bus.r0_done, bus.r1_done, bus.err_timeout});
    end
    n_cmp++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_bus: got addr=%h wdata=%h want 0/0", bus.mem_addr, bus.mem_wdata);
    end
    n_cmp++;
    if (bus.rd_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rd_data: got %h want 0", bus.rd_data);
    end
    rst = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_read();
    int ra, da;
    sram[idx(32'h100)] = 32'hDEADBEEF;
    ctl_lat     = 6;
    bus.r0_addr = 32'h100;
    bus.r0_rd   = 1'b1;
    tick();
    n_cmp++;
    if (bus.mem_rd_en !== 1'b1 || bus.mem_wr_en !== 1'b0 || bus.mem_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL read_grant: got rd=%b wr=%b addr=%h want 1 0 00000100",
               bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr);
    end
    wait_done(0, 40, ra, da);
    bus.r0_rd = 1'b0;
    n_cmp++;
    if (da < 0 || da != ra + 1) begin
      n_bad++;
      $display("FAIL read_done_latency: got done at %0d ready at %0d want done=ready+1", da, ra);
    end
    n_cmp++;
    if (bus.rd_data !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL read_data: got %h want deadbeef", bus.rd_data);
    end
    n_cmp++;
    if (bus.mem_rd_en !== 1'b0 || bus.r1_done !== 1'b0) begin
      n_bad++;
      $display("FAIL read_done_cycle: got rd_en=%b r1_done=%b want 0 0", bus.mem_rd_en, bus.r1_done);
    end
    tick();
    n_cmp++;
    if (bus.r0_done !== 1'b0) begin
      n_bad++;
      $display("FAIL read_done_pulse: got r0_done=%b one cycle later want 0", bus.r0_done);
    end
    $display("txn read p0 addr=00000100 rd_data=%h", bus.rd_data);
  endtask

  task automatic test_write();
    bit stable, seen;
    bus.r1_addr  = 32'h204;
    bus.r1_wdata = 32'h12345678;
    bus.r1_wr    = 1'b1;
    tick();
    n_cmp++;
    if (bus.mem_wr_en !== 1'b1 || bus.mem_rd_en !== 1'b0 || bus.mem_addr !== 32'h204 ||
        bus.mem_wdata !== 32'h12345678) begin
      n_bad++;
      $display("FAIL write_grant: got wr=%b rd=%b addr=%h wdata=%h want 1 0 00000204 12345678",
               bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata);
    end
    stable = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.r1_done) seen = 1'b1;
      else if (bus.mem_wr_en !== 1'b1 || bus.mem_addr !== 32'h204 || bus.mem_wdata !== 32'h12345678)
        stable = 1'b0;
    end
    bus.r1_wr = 1'b0;
    n_cmp++;
    if (!seen || !stable) begin
      n_bad++;
      $display("FAIL write_hold: got done_seen=%b stable=%b want 1 1", seen, stable);
    end
    n_cmp++;
    if (bus.rd_data !== 32'hDEADBEEF || bus.r0_done !== 1'b0) begin
      n_bad++;
      $display("FAIL write_rd_data: got rd_data=%h r0_done=%b want deadbeef 0", bus.rd_data, bus.r0_done);
    end
    n_cmp++;
    if (sram[idx(32'h204)] !== 32'h12345678) begin
      n_bad++;
      $display("FAIL write_mem: got %h want 12345678", sram[idx(32'h204)]);
    end
    tick();
    $display("txn write p1 addr=00000204 wdata=12345678");
  endtask

  task automatic test_fairness();
    int gport[6], dport[6], gaps[6];
    int ng, nd, low_run, first_at;
    logic en, prev_en;
    sram[idx(32'h10)] = 32'hA0A0A0A0;
    sram[idx(32'h20)] = 32'hB1B1B1B1;
    ctl_lat = 2;
    rst = 1'b1;
    bus.r0_addr = 32'h10; bus.r0_rd = 1'b1;
    bus.r1_addr = 32'h20; bus.r1_rd = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ng = 0; nd = 0; low_run = 0; first_at = -1; prev_en = 1'b0;
    for (int c = 1; c <= 200 && nd < 6; c++) begin
      tick();
      en = bus.mem_rd_en | bus.mem_wr_en;
      if (en && !prev_en) begin
        if (ng == 0) first_at = c;
        if (ng < 6) begin
          gport[ng] = (bus.mem_addr == 32'h20) ? 1 : 0;
          gaps[ng]  = low_run;
        end
        ng++;
      end
      low_run = en ? 0 : low_run + 1;
      if (bus.r0_done && nd < 6) begin dport[nd] = 0; nd++; end
      if (bus.r1_done && nd < 6) begin dport[nd] = 1; nd++; end
      prev_en = en;
    end
    bus.r0_rd = 1'b0;
    bus.r1_rd = 1'b0;
    n_cmp++;
    if (ng < 6 || nd < 6 || first_at != 1) begin
      n_bad++;
      $display("FAIL fair_progress: got grants=%0d dones=%0d first_at=%0d want 6 6 1", ng, nd, first_at);
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_cmp++;
        if (gport[k] != k % 2 || dport[k] != k % 2) begin
          n_bad++;
          $display("FAIL fair_order[%0d]: got grant=%0d done=%0d want %0d", k, gport[k], dport[k], k % 2);
        end
        // DONE cycle plus the IDLE arbitration cycle separate grants.
        if (k > 0) begin
          n_cmp++;
          if (gaps[k] != 2) begin
            n_bad++;
            $display("FAIL fair_gap[%0d]: got %0d idle cycles want 2", k, gaps[k]);
          end
        end
      end
    end
    n_cmp++;
    if (bus.rd_data !== 32'hB1B1B1B1) begin
      n_bad++;
      $display("FAIL fair_rd_data: got %h want b1b1b1b1", bus.rd_data);
    end
    tick();
    $display("txn fairness grants=%0d dones=%0d", ng, nd);
  endtask

  task automatic test_timeout();
    int en_cyc, extra, ra, da;
    bit seen, early_err;
    ctl_stall    = 1'b1;
    bus.r0_addr  = 32'h40;
    bus.r0_wdata = 32'h55AA55AA;
    bus.r0_wr    = 1'b1;
    en_cyc = 0; seen = 1'b0; early_err = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (bus.r0_done) seen = 1'b1;
      else if (bus.mem_wr_en) begin
        en_cyc++;
        if (bus.err_timeout !== 1'b0) early_err = 1'b1;
      end
    end
    bus.r0_wr = 1'b0;
    n_cmp++;
    // wd_cnt is 0 in the first BUSY cycle; expiry at wd_cnt==TIMEOUT.
    if (!seen || en_cyc != TIMEOUT + 1 || early_err) begin
      n_bad++;
      $display("FAIL timeout_len: got done=%b busy=%0d early_err=%b want 1 %0d 0",
               seen, en_cyc, early_err, TIMEOUT + 1);
    end
    n_cmp++;
    if (bus.err_timeout !== 1'b1 || bus.rd_data !== 32'hB1B1B1B1) begin
      n_bad++;
      $display("FAIL timeout_flag: got err=%b rd_data=%h want 1 b1b1b1b1", bus.err_timeout, bus.rd_data);
    end
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.r0_done) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL timeout_single_done: got %0d extra pulses want 0", extra);
    end
    ctl_stall = 1'b0;
    ctl_lat   = 3;
    sram[idx(32'h30)] = 32'hC3C3C3C3;
    bus.r1_addr = 32'h30;
    bus.r1_rd   = 1'b1;
    wait_done(1, 40, ra, da);
    bus.r1_rd = 1'b0;
    n_cmp++;
    if (da < 0 || bus.err_timeout !== 1'b1 || bus.rd_data !== 32'hC3C3C3C3) begin
      n_bad++;
      $display("FAIL timeout_sticky: got done_at=%0d err=%b rd_data=%h want >0 1 c3c3c3c3",
               da, bus.err_timeout, bus.rd_data);
    end
    tick();
    $display("txn timeout p0 busy=%0d then read p1 rd_data=%h", en_cyc, bus.rd_data);
  endtask

  task automatic test_reset_mid();
    int ra, da;
    ctl_lat = 6;
    sram[idx(32'h60)] = 32'hD4D4D4D4;
    bus.r0_addr = 32'h50;
    bus.r0_rd   = 1'b1;
    tick();
    tick();
    tick();
    bus.r1_addr = 32'h60;
    bus.r1_rd   = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mem_rd_en, bus.mem_wr_en, bus.r0_done, bus.r1_done, bus.err_timeout} !== 5'b0 ||
        bus.mem_addr !== 32'h0 || bus.rd_data !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_async: got ctrl=%b addr=%h rd_data=%h want 00000 0 0",
               {bus.mem_rd_en, bus.mem_wr_en, bus.r0_done, bus.r1_done, bus.err_timeout},
               bus.mem_addr, bus.rd_data);
    end
    bus.r0_rd = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h60) begin
      n_bad++;
      $display("FAIL rst_regrant: got rd_en=%b addr=%h want 1 00000060", bus.mem_rd_en, bus.mem_addr);
    end
    wait_done(1, 40, ra, da);
    bus.r1_rd = 1'b0;
    n_cmp++;
    if (da < 0 || bus.rd_data !== 32'hD4D4D4D4) begin
      n_bad++;
      $display("FAIL rst_after_read: got done_at=%0d rd_data=%h want >0 d4d4d4d4", da, bus.rd_data);
    end
    tick();
    $display("txn reset mid-busy then read p1 rd_data=%h", bus.rd_data);
  endtask

  task automatic test_rdwr_both();
    int ra, da;
    bus.r0_addr  = 32'h70;
    bus.r0_wdata = 32'hCAFEF00D;
    bus.r0_rd    = 1'b1;
    bus.r0_wr    = 1'b1;
    tick();
    n_cmp++;
    if (bus.mem_wr_en !== 1'b1 || bus.mem_rd_en !== 1'b0) begin
      n_bad++;
      $display("FAIL rdwr_op: got wr=%b rd=%b want 1 0", bus.mem_wr_en, bus.mem_rd_en);
    end
    wait_done(0, 40, ra, da);
    bus.r0_rd = 1'b0;
    bus.r0_wr = 1'b0;
    n_cmp++;
    if (da < 0 || sram[idx(32'h70)] !== 32'hCAFEF00D || bus.rd_data !== 32'hD4D4D4D4) begin
      n_bad++;
      $display("FAIL rdwr_result: got done_at=%0d mem=%h rd_data=%h want >0 cafef00d d4d4d4d4",
               da, sram[idx(32'h70)], bus.rd_data);
    end
    tick();
    $display("txn rd+wr p0 issued as write");
  endtask

  // Randomized traffic on both ports against a transaction-level model.
  task automatic test_random(input int cycles);
    bit          act[2];
    logic        rdv[2], wrv[2];
    logic [31:0] ad[2], wd[2];
    bit          prev_req[2];
    logic        en, prev_en, prev_rdy, prev_done, ends, exp_en, exp_d0, exp_d1, dn, cur_wr;
    logic [31:0] exp_rd, rdy_data;
    int          last_win, cur_port, busy_cnt, k;
    clear_reqs();
    pulse_reset();
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; rdv[p] = 1'b0; wrv[p] = 1'b0; ad[p] = '0; wd[p] = '0; prev_req[p] = 1'b0;
    end
    prev_en = 1'b0; prev_rdy = 1'b0; prev_done = 1'b0; cur_wr = 1'b0;
    exp_rd = '0; rdy_data = '0; last_win = 1; cur_port = 0; busy_cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      en     = bus.mem_rd_en | bus.mem_wr_en;
      ends   = prev_en && (prev_rdy || busy_cnt == TIMEOUT + 1);
      exp_en = prev_en ? !ends : (!prev_done && (prev_req[0] || prev_req[1]));
      n_cmp++;
      if (en !== exp_en) begin
        n_bad++;
        $display("FAIL rand_enable@%0d: got %b want %b", c, en, exp_en);
      end
      if (ends && !cur_wr) exp_rd = rdy_data;
      exp_d0 = ends && (cur_port == 0);
      exp_d1 = ends && (cur_port == 1);
      n_cmp++;
      if (bus.r0_done !== exp_d0 || bus.r1_done !== exp_d1) begin
        n_bad++;
        $display("FAIL rand_done@%0d: got %b%b want %b%b", c, bus.r1_done, bus.r0_done, exp_d1, exp_d0);
      end
      n_cmp++;
      if (bus.rd_data !== exp_rd) begin
        n_bad++;
        $display("FAIL rand_rd_data@%0d: got %h want %h", c, bus.rd_data, exp_rd);
      end
      if (ends) begin
        last_win = cur_port;
        $display("txn random p%0d %s addr=%h rd_data=%h", cur_port, cur_wr ? "wr" : "rd",
                 ad[cur_port], bus.rd_data);
      end
      if (!prev_en && exp_en) begin
        if (prev_req[0] && prev_req[1]) cur_port = 1 - last_win;
        else cur_port = prev_req[1] ? 1 : 0;
        cur_wr   = wrv[cur_port];
        busy_cnt = 0;
        n_cmp++;
        if (bus.mem_wr_en !== cur_wr || bus.mem_rd_en !== !cur_wr || bus.mem_addr !== ad[cur_port] ||
            (cur_wr && bus.mem_wdata !== wd[cur_port])) begin
          n_bad++;
          $display("FAIL rand_grant@%0d: got wr=%b addr=%h wdata=%h want p%0d wr=%b addr=%h wdata=%h",
                   c, bus.mem_wr_en, bus.mem_addr, bus.mem_wdata, cur_port, cur_wr, ad[cur_port], wd[cur_port]);
        end
      end else if (en && exp_en) begin
        n_cmp++;
        if (bus.mem_addr !== ad[cur_port]) begin
          n_bad++;
          $display("FAIL rand_hold@%0d: got addr=%h want %h", c, bus.mem_addr, ad[cur_port]);
        end
      end
      if (en) busy_cnt++;
      prev_en   = en;
      prev_rdy  = bus.mem_ready && en;
      rdy_data  = bus.mem_rdata;
      prev_done = bus.r0_done | bus.r1_done;
      for (int p = 0; p < 2; p++) begin
        dn = (p == 0) ? bus.r0_done : bus.r1_done;
        if (dn) begin
          act[p] = 1'b0;
        end else if (!act[p] && $urandom_range(0, 2) == 0) begin
          act[p] = 1'b1;
          k      = int'($urandom_range(0, 3));
          rdv[p] = (k != 1);
          wrv[p] = (k == 1) || (k == 2);
          ad[p]  = 32'($urandom_range(0, 63)) << 2;
          wd[p]  = $urandom;
        end
        prev_req[p] = act[p];
      end
      bus.r0_rd = act[0] & rdv[0]; bus.r0_wr = act[0] & wrv[0];
      bus.r0_addr = ad[0]; bus.r0_wdata = wd[0];
      bus.r1_rd = act[1] & rdv[1]; bus.r1_wr = act[1] & wrv[1];
      bus.r1_addr = ad[1]; bus.r1_wdata = wd[1];
      if (!en) ctl_lat = int'($urandom_range(1, 6));
    end
    clear_reqs();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) sram[i] = 32'h0;
    clear_reqs();
    test_reset();
    test_read();
    test_write();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_rdwr_both();
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
